// File: rtl/lcd_bus_receiver_if.sv
// LCD 4-bit write bus pins (E, RS, RW, DB[7:4]) as seen by the receiver.
// The controller side drives the pins and the receiver samples them.
// There is no ready/valid handshake on this bus. A nibble is transferred
// when E falls, and RS/RW/DB must be stable while E is high.
interface lcd_bus_receiver_if;
   logic       iLCD_Enabled;
   logic       iLCD_RegisterSelect;
   logic       iLCD_ReadWrite;
   logic [3:0] iLCD_Data;

   modport master (
      output iLCD_Enabled,
      output iLCD_RegisterSelect,
      output iLCD_ReadWrite,
      output iLCD_Data
   );

   modport slave (
      input iLCD_Enabled,
      input iLCD_RegisterSelect,
      input iLCD_ReadWrite,
      input iLCD_Data
   );
endinterface

// File: rtl/lcd_bus_receiver.sv
// Responder end of an HD44780-style 4-bit LCD write bus.
// The bus pins are synchronized and each falling E edge becomes one nibble strobe.
// The receiver follows the power-on 8-bit to 4-bit switch and pairs nibbles into bytes.
// It models the controller busy time and the display-on, entry I/D and address registers.
// Short E pulses, read cycles and writes made while busy produce one-cycle error pulses.
// oByteValid rises on the 4th clock edge, counting the edge that first samples E low.
module lcd_bus_receiver #(
   parameter int BUSY_CYCLES       = 2000,
   parameter int CLEAR_BUSY_CYCLES = 82000,
   parameter int MIN_E_HIGH        = 12
) (
   input  logic              Clock,
   input  logic              Reset,
   lcd_bus_receiver_if.slave bus,
   output logic              oByteValid,
   output logic [7:0]        oByte,
   output logic              oByteIsData,
   output logic              oMode4,
   output logic              oBusy,
   output logic              oDisplayOn,
   output logic [6:0]        oAddress,
   output logic              oBusyViolation,
   output logic              oPulseErr,
   output logic              oProtoErr,
   output logic [1:0]        oState
);

   localparam int BMAX = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
   localparam int BCW  = $clog2(BMAX + 1);
   localparam int ECW  = $clog2(MIN_E_HIGH + 1);
   localparam logic [BCW-1:0] BUSY_LOAD  = BCW'(BUSY_CYCLES);
   localparam logic [BCW-1:0] CLEAR_LOAD = BCW'(CLEAR_BUSY_CYCLES);
   localparam logic [ECW-1:0] E_SAT      = ECW'(MIN_E_HIGH);

   typedef enum logic [1:0] {
      ST_INIT8    = 2'd0,
      ST_MODE4_HI = 2'd1,
      ST_MODE4_LO = 2'd2
   } state_t;

   logic           r_e_s1, r_e_s2, r_e_s3;
   logic           r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
   logic [3:0]     r_db_s1, r_db_s2;
   logic           r_cap_rs, r_cap_rw;
   logic [3:0]     r_cap_db;
   logic [ECW-1:0] r_ehigh_cnt;
   logic           r_stb, r_stb_short, r_stb_rs, r_stb_rw;
   logic [3:0]     r_stb_db;
   state_t         r_state;
   logic [3:0]     r_hi;
   logic           r_hi_rs;
   logic           r_id;
   logic [BCW-1:0] r_busy_cnt;

   logic           w_fall;
   logic [7:0]     w_byte;
   logic           w_is_clear;
   logic           w_busy_viol;

   assign w_fall      = r_e_s3 & ~r_e_s2;
   assign w_byte      = {r_hi, r_stb_db};
   // Commands 0x01..0x03 (clear / return home) take the long busy time.
   assign w_is_clear  = ~r_hi_rs & (w_byte[7:2] == 6'd0) & (w_byte[1:0] != 2'd0);
   // Busy still asserted after this edge. A counter at 1 expires on this same edge.
   assign w_busy_viol = (r_busy_cnt > BCW'(1));
   assign oBusy       = (r_busy_cnt != '0);
   assign oState      = r_state;

   // Synchronize the pins, keep the last RS/RW/DB seen with E high, and time the E-high width.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_e_s1      <= 1'b0;
         r_e_s2      <= 1'b0;
         r_e_s3      <= 1'b0;
         r_rs_s1     <= 1'b0;
         r_rs_s2     <= 1'b0;
         r_rw_s1     <= 1'b0;
         r_rw_s2     <= 1'b0;
         r_db_s1     <= 4'd0;
         r_db_s2     <= 4'd0;
         r_cap_rs    <= 1'b0;
         r_cap_rw    <= 1'b0;
         r_cap_db    <= 4'd0;
         r_ehigh_cnt <= '0;
      end else begin
         r_e_s1  <= bus.iLCD_Enabled;
         r_e_s2  <= r_e_s1;
         r_e_s3  <= r_e_s2;
         r_rs_s1 <= bus.iLCD_RegisterSelect;
         r_rs_s2 <= r_rs_s1;
         r_rw_s1 <= bus.iLCD_ReadWrite;
         r_rw_s2 <= r_rw_s1;
         r_db_s1 <= bus.iLCD_Data;
         r_db_s2 <= r_db_s1;
         if (r_e_s2) begin
            r_cap_rs <= r_rs_s2;
            r_cap_rw <= r_rw_s2;
            r_cap_db <= r_db_s2;
            if (r_ehigh_cnt != E_SAT) r_ehigh_cnt <= r_ehigh_cnt + 1'b1;
         end else begin
            r_ehigh_cnt <= '0;
         end
      end
   end

   // Register the strobe together with its nibble and a flag marking a too-short E pulse.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_stb       <= 1'b0;
         r_stb_short <= 1'b0;
         r_stb_rs    <= 1'b0;
         r_stb_rw    <= 1'b0;
         r_stb_db    <= 4'd0;
      end else begin
         r_stb <= w_fall;
         if (w_fall) begin
            r_stb_short <= (r_ehigh_cnt < E_SAT);
            r_stb_rs    <= r_cap_rs;
            r_stb_rw    <= r_cap_rw;
            r_stb_db    <= r_cap_db;
         end
      end
   end

   // Bus FSM. It handles the mode switch and byte assembly, runs the busy timer and decodes commands.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state        <= ST_INIT8;
         r_hi           <= 4'd0;
         r_hi_rs        <= 1'b0;
         r_id           <= 1'b1;
         r_busy_cnt     <= '0;
         oByteValid     <= 1'b0;
         oByte          <= 8'd0;
         oByteIsData    <= 1'b0;
         oMode4         <= 1'b0;
         oDisplayOn     <= 1'b0;
         oAddress       <= 7'd0;
         oBusyViolation <= 1'b0;
         oPulseErr      <= 1'b0;
         oProtoErr      <= 1'b0;
      end else begin
         oByteValid     <= 1'b0;
         oBusyViolation <= 1'b0;
         oPulseErr      <= 1'b0;
         oProtoErr      <= 1'b0;
         if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - 1'b1;
         if (r_stb) begin
            if (r_stb_short) begin
               oPulseErr <= 1'b1;
            end else if (r_stb_rw) begin
               oProtoErr <= 1'b1;
            end else begin
               if ((r_state != ST_INIT8) && w_busy_viol) oBusyViolation <= 1'b1;
               case (r_state)
                  ST_INIT8: begin
                     if (r_stb_db == 4'h2) begin
                        r_state <= ST_MODE4_HI;
                        oMode4  <= 1'b1;
                     end
                  end
                  ST_MODE4_HI: begin
                     r_hi    <= r_stb_db;
                     r_hi_rs <= r_stb_rs;
                     r_state <= ST_MODE4_LO;
                  end
                  ST_MODE4_LO: begin
                     oByte       <= w_byte;
                     oByteIsData <= r_hi_rs;
                     oByteValid  <= 1'b1;
                     r_state     <= ST_MODE4_HI;
                     r_busy_cnt  <= w_is_clear ? CLEAR_LOAD : BUSY_LOAD;
                     if (r_hi_rs) begin
                        oAddress <= r_id ? (oAddress + 7'd1) : (oAddress - 7'd1);
                     end else if (w_byte[7]) begin
                        oAddress <= w_byte[6:0];
                     end else if (w_byte[6:4] != 3'd0) begin
                        // Function set, CGRAM address and shift leave the tracked registers alone.
                        oAddress <= oAddress;
                     end else if (w_byte[3]) begin
                        oDisplayOn <= w_byte[2];
                     end else if (w_byte[2]) begin
                        r_id <= w_byte[1];
                     end else if (w_byte[1:0] != 2'd0) begin
                        oAddress <= 7'd0;
                     end
                  end
                  default: r_state <= ST_INIT8;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver. It drives nibbles on the LCD bus and checks the outputs against
// a table of hand-computed vectors and against a byte-level model of the controller rules.
module tb_lcd_bus_receiver;

   localparam int BUSY = 40;
   localparam int CLR  = 300;
   localparam int MINE = 12;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lcd_bus_receiver_if bus ();

   logic       oByteValid, oByteIsData, oMode4, oBusy, oDisplayOn;
   logic       oBusyViolation, oPulseErr, oProtoErr;
   logic [7:0] oByte;
   logic [6:0] oAddress;
   logic [1:0] oState;

   lcd_bus_receiver #(
      .BUSY_CYCLES(BUSY), .CLEAR_BUSY_CYCLES(CLR), .MIN_E_HIGH(MINE)
   ) dut (
      .Clock(clk), .Reset(rst), .bus(bus),
      .oByteValid(oByteValid), .oByte(oByte), .oByteIsData(oByteIsData),
      .oMode4(oMode4), .oBusy(oBusy), .oDisplayOn(oDisplayOn), .oAddress(oAddress),
      .oBusyViolation(oBusyViolation), .oPulseErr(oPulseErr), .oProtoErr(oProtoErr),
      .oState(oState)
   );

   // ---------------- monitor (negedge) ----------------
   logic [8:0] obs_b [0:1023];
   int         obs_t [0:1023];
   int         obs_wr = 0;
   int         n_bv = 0, n_pe = 0, n_pr = 0;

   always @(negedge clk) begin
      if (oByteValid && obs_wr < 1024) begin
         obs_b[obs_wr] = {oByteIsData, oByte};
         obs_t[obs_wr] = cyc;
         obs_wr = obs_wr + 1;
      end
      if (oBusyViolation) n_bv = n_bv + 1;
      if (oPulseErr)      n_pe = n_pe + 1;
      if (oProtoErr)      n_pr = n_pr + 1;
   end

   // ---------------- scoreboard / checks ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   int         obs_rd   = 0;
   logic [8:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drain();
      logic [8:0] e;
      while (obs_rd < obs_wr) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none", obs_b[obs_rd]);
         end else begin
            e = exp_q.pop_front();
            check("byte_stream", 32'(obs_b[obs_rd]), 32'(e));
         end
         obs_rd++;
      end
   endtask

   // ---------------- reference model ----------------
   bit m_mode4, m_pend, m_hi_rs, m_disp, m_id;
   int m_hi, m_addr;
   int e_pe = 0, e_pr = 0, e_bv = 0;

   task automatic model_reset();
      m_mode4 = 0; m_pend = 0; m_hi = 0; m_hi_rs = 0;
      m_addr = 0; m_disp = 0; m_id = 1;
      exp_q.delete();
   endtask

   task automatic model_byte(input bit rs, input int b);
      if (rs)            m_addr = (m_addr + (m_id ? 1 : 127)) % 128;
      else if (b >= 128) m_addr = b - 128;
      else if (b >= 16)  m_addr = m_addr;
      else if (b >= 8)   m_disp = ((b / 4) % 2) != 0;
      else if (b >= 4)   m_id   = ((b / 2) % 2) != 0;
      else if (b >= 1)   m_addr = 0;
   endtask

   task automatic model_nib(input bit rs, input bit rw, input int nib, input int width);
      int b;
      if (width < MINE)  e_pe++;
      else if (rw)       e_pr++;
      else if (!m_mode4) begin
         if (nib == 2) m_mode4 = 1;
      end else if (!m_pend) begin
         m_pend = 1; m_hi = nib; m_hi_rs = rs;
      end else begin
         b = m_hi * 16 + nib;
         m_pend = 0;
         exp_q.push_back({m_hi_rs, 8'(b)});
         model_byte(m_hi_rs, b);
      end
   endtask

   // ---------------- drivers (enter and leave on a negedge) ----------------
   int t_fall = 0;   // number of the edge that first samples E low

   task automatic send_nib(input logic rs, input logic rw, input logic [3:0] nib,
                           input int width, input int gap);
      bus.iLCD_RegisterSelect = rs;
      bus.iLCD_ReadWrite      = rw;
      bus.iLCD_Data           = nib;
      repeat (2) @(negedge clk);
      bus.iLCD_Enabled = 1'b1;
      repeat (width) @(negedge clk);
      bus.iLCD_Enabled = 1'b0;
      t_fall = cyc + 1;
      model_nib(rs, rw, int'(nib), width);
      repeat (gap) @(negedge clk);
   endtask

   // Same nibble, timed so that the edge sampling E low is number f.
   task automatic send_nib_at(input logic rs, input logic [3:0] nib, input int width,
                              input int f, input int gap);
      while (cyc < f - 3 - width) @(negedge clk);
      send_nib(rs, 1'b0, nib, width, gap);
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] b, input int gap_lo);
      send_nib(rs, 1'b0, b[7:4], 20, 10);
      send_nib(rs, 1'b0, b[3:0], 20, gap_lo);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},  32'(oByteValid),  0);
      check({tag, "_byte"},   32'(oByte),       0);
      check({tag, "_isdata"}, 32'(oByteIsData), 0);
      check({tag, "_mode4"},  32'(oMode4),      0);
      check({tag, "_busy"},   32'(oBusy),       0);
      check({tag, "_dispon"}, 32'(oDisplayOn),  0);
      check({tag, "_addr"},   32'(oAddress),    0);
      check({tag, "_errs"},   32'({oBusyViolation, oPulseErr, oProtoErr}), 0);
      check({tag, "_state"},  32'(oState),      0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rs;
      logic [7:0] b;
      logic [6:0] addr;
      logic       disp;
   } vec_t;
   vec_t tbl [24];

   // ---------------- watchdog ----------------
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int t_emit, k, idx, gap;
      logic       rs;
      logic [7:0] b;

      tbl[0]  = '{1'b0, 8'h28, 7'h00, 1'b0};
      tbl[1]  = '{1'b0, 8'h06, 7'h00, 1'b0};
      tbl[2]  = '{1'b0, 8'h0C, 7'h00, 1'b1};
      tbl[3]  = '{1'b0, 8'h85, 7'h05, 1'b1};
      tbl[4]  = '{1'b1, 8'h41, 7'h06, 1'b1};
      tbl[5]  = '{1'b0, 8'h04, 7'h06, 1'b1};
      tbl[6]  = '{1'b1, 8'h42, 7'h05, 1'b1};
      tbl[7]  = '{1'b0, 8'h80, 7'h00, 1'b1};
      tbl[8]  = '{1'b1, 8'h43, 7'h7F, 1'b1};
      tbl[9]  = '{1'b0, 8'h06, 7'h7F, 1'b1};
      tbl[10] = '{1'b1, 8'h44, 7'h00, 1'b1};
      tbl[11] = '{1'b0, 8'h08, 7'h00, 1'b0};
      tbl[12] = '{1'b0, 8'h0F, 7'h00, 1'b1};
      tbl[13] = '{1'b0, 8'h9A, 7'h1A, 1'b1};
      tbl[14] = '{1'b0, 8'h02, 7'h00, 1'b1};
      tbl[15] = '{1'b0, 8'hC5, 7'h45, 1'b1};
      tbl[16] = '{1'b0, 8'h3F, 7'h45, 1'b1};
      tbl[17] = '{1'b0, 8'h5A, 7'h45, 1'b1};
      tbl[18] = '{1'b0, 8'h1C, 7'h45, 1'b1};
      tbl[19] = '{1'b0, 8'h03, 7'h00, 1'b1};
      tbl[20] = '{1'b0, 8'hE0, 7'h60, 1'b1};
      tbl[21] = '{1'b0, 8'h07, 7'h60, 1'b1};
      tbl[22] = '{1'b1, 8'h20, 7'h61, 1'b1};
      tbl[23] = '{1'b0, 8'h0B, 7'h61, 1'b0};

      bus.iLCD_Enabled = 1'b0;
      bus.iLCD_RegisterSelect = 1'b0;
      bus.iLCD_ReadWrite = 1'b0;
      bus.iLCD_Data = 4'h0;
      model_reset();

      // Reset values
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Power-on nibbles 3,3,3,2
      for (int i = 0; i < 3; i++) begin
         send_nib(1'b0, 1'b0, 4'h3, 20, 100);
         check("init_mode4_low", 32'(oMode4), 0);
      end
      send_nib(1'b0, 1'b0, 4'h2, 20, 100);
      check("init_mode4_set", 32'(oMode4), 1);
      check("init_no_bytes", 32'(obs_wr), 0);
      check("init_busy", 32'(oBusy), 0);

      // Table-driven command/data decode
      for (int i = 0; i < 24; i++) begin
         send_byte(tbl[i].rs, tbl[i].b, CLR + 20);
         if (i == 0) begin
            idx = (obs_wr > 0) ? obs_wr - 1 : 0;
            check("latency", 32'(obs_t[idx]), 32'(t_fall + 3));
         end
         drain();
         check($sformatf("tbl%0d_byte", i),   32'(oByte),       32'(tbl[i].b));
         check($sformatf("tbl%0d_isdata", i), 32'(oByteIsData), 32'(tbl[i].rs));
         check($sformatf("tbl%0d_addr", i),   32'(oAddress),    32'(tbl[i].addr));
         check($sformatf("tbl%0d_dispon", i), 32'(oDisplayOn),  32'(tbl[i].disp));
      end

      // Clear, early nibble -> busy violation, long busy window
      send_byte(1'b0, 8'h01, 100);
      drain();
      t_emit = obs_t[(obs_wr > 0) ? obs_wr - 1 : 0];
      check("clear_addr", 32'(oAddress), 0);
      send_nib(1'b0, 1'b0, 4'hF, 20, 10);
      e_bv++;
      check("clear_busyviol", 32'(n_bv), 32'(e_bv));
      while (cyc < t_emit + CLR - 1) @(negedge clk);
      check("clear_busy_last", 32'(oBusy), 1);
      @(negedge clk);
      check("clear_busy_done", 32'(oBusy), 0);
      send_nib(1'b0, 1'b0, 4'hF, 20, 60);
      drain();
      check("ff_byte", 32'(oByte), 32'hFF);
      check("ff_addr", 32'(oAddress), 32'h7F);
      send_byte(1'b1, 8'h41, 60);
      drain();
      check("wrap_addr", 32'(oAddress), 0);
      check("wrap_isdata", 32'(oByteIsData), 1);

      // Busy edge: expiring on the processing edge is legal, one cycle earlier is not
      send_byte(1'b0, 8'h14, 2);
      t_emit = t_fall + 3;
      send_nib_at(1'b0, 4'h1, 20, t_emit + BUSY - 3, 2);
      send_nib(1'b0, 1'b0, 4'h4, 20, 2);
      check("busy_edge_ok", 32'(n_bv), 32'(e_bv));
      t_emit = t_fall + 3;
      send_nib_at(1'b0, 4'h1, 20, t_emit + BUSY - 4, 2);
      e_bv++;
      send_nib(1'b0, 1'b0, 4'h4, 20, BUSY + 20);
      check("busy_edge_viol", 32'(n_bv), 32'(e_bv));
      drain();

      // Short E pulses and read cycles are dropped without moving the phase
      send_nib(1'b0, 1'b0, 4'h8, 5, 30);
      check("short_pulse", 32'(n_pe), 32'(e_pe));
      send_nib(1'b0, 1'b0, 4'h8, 20, 10);
      send_nib(1'b0, 1'b1, 4'hF, 20, 10);
      check("rw_proto", 32'(n_pr), 32'(e_pr));
      send_nib(1'b0, 1'b0, 4'h7, MINE - 1, 10);
      send_nib(1'b0, 1'b0, 4'h3, MINE, BUSY + 20);
      drain();
      check("phase_byte", 32'(oByte), 32'h83);
      check("phase_addr", 32'(oAddress), 32'h03);
      check("phase_pe", 32'(n_pe), 32'(e_pe));
      check("phase_bv", 32'(n_bv), 32'(e_bv));

      // Reset between high and low nibble while busy
      send_byte(1'b0, 8'h0F, 60);
      send_byte(1'b0, 8'hA3, 2);
      send_nib(1'b0, 1'b0, 4'h4, 20, 5);
      e_bv++;
      drain();
      check("prereset_busy", 32'(oBusy), 1);
      #3 rst = 1'b1;
      #2;
      check_all_zero("midreset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_nib(1'b0, 1'b0, 4'h4, 20, 30);
      send_nib(1'b0, 1'b0, 4'h1, 20, 30);
      check("after_reset_init8", 32'(oState), 0);
      check("after_reset_nobyte", 32'(obs_wr - obs_rd), 0);
      send_nib(1'b0, 1'b0, 4'h2, 20, 30);
      check("after_reset_mode4", 32'(oMode4), 1);

      // Randomized traffic against the model
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 9);
         if (k == 0) begin
            send_nib(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)),
                     $urandom_range(1, MINE - 1), 10);
         end else if (k == 1) begin
            send_nib(1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)), 20, 10);
         end else begin
            rs = 1'($urandom_range(0, 1));
            b  = 8'($urandom_range(0, 255));
            gap = (!rs && b >= 8'h01 && b <= 8'h03) ? CLR + 20 : BUSY + 20;
            send_nib(rs, 1'b0, b[7:4], $urandom_range(MINE, 25), 10);
            if ($urandom_range(0, 3) == 0)
               send_nib(rs, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        $urandom_range(1, MINE - 1), 10);
            send_nib(rs, 1'b0, b[3:0], $urandom_range(MINE, 25), gap);
            drain();
            check($sformatf("rnd%0d_addr", i),   32'(oAddress),   32'(m_addr));
            check($sformatf("rnd%0d_dispon", i), 32'(oDisplayOn), 32'(m_disp));
         end
      end
      drain();
      check("rnd_pulse_errs", 32'(n_pe), 32'(e_pe));
      check("rnd_proto_errs", 32'(n_pr), 32'(e_pr));
      check("rnd_busy_viols", 32'(n_bv), 32'(e_bv));
      check("bytes_missing", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
